// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for MIPS DIV/DIVU.
// One quotient bit per cycle. Operands are reduced to magnitudes on accept,
// and the signs are restored in the FINISH cycle. Quotient goes to LO and
// remainder goes to HI. busy is registered so the hazard unit never sees a
// combinational path from start.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             busy_q;

    // Partial remainder after the left shift. It is one bit wider than the
    // divisor, so the trial subtract can be judged by a plain compare.
    logic [WIDTH:0]   shifted;
    logic             fits;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return {WIDTH{1'b0}} - v;
    endfunction

    // Negative two's-complement operands are reduced to a magnitude, but only
    // in signed mode. The magnitude of 0x80000000 wraps to 0x80000000. That
    // value is still correct when it is treated as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        return (sgn && v[WIDTH-1]) ? negate(v) : v;
    endfunction

    // Shift-and-trial-subtract datapath for one restoring step
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvs_q});
    end

    // Next-state logic, datapath updates and the done pulse
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    rem_d   = '0;
                    quo_d   = magnitude(opa, signed_div);
                    dvs_d   = magnitude(opb, signed_div);
                    qneg_d  = signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                    rneg_d  = signed_div & opa[WIDTH-1];
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    rem_d = fits ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], fits};
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (!annul) begin
                    lo_d = qneg_q ? negate(quo_q) : quo_q;
                    hi_d = rneg_q ? negate(rem_q) : rem_q;
                    done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and result registers, cleared asynchronously
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving MIPS DIV/DIVU in the execute stage. It accepts a start request from the E stage and asserts `busy` for the full iteration. The hazard unit uses `busy` to hold fetch/decode. On completion it writes quotient to LO and remainder to HI in registered outputs.

## Interface
- `WIDTH`, 32, operand width. Only 32 is supported. The counter width is derived as clog2(WIDTH)+1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  E-stage DIV/DIVU valid. Sampled only in IDLE.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU. Sampled with `start`.
- `annul`  in  1  pipeline flush or exception. Cancels any operation in progress.
- `opa`  in  32  dividend (rs). Sampled with `start`.
- `opb`  in  32  divisor (rt). Sampled with `start`.
- `busy`  out  1  high while an accepted operation is in progress. Feeds the hazard unit.
- `done`  out  1  one-cycle pulse when `hi`/`lo` receive a new result.
- `hi`  out  32  remainder register.
- `lo`  out  32  quotient register.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE, with `start`=1 and `annul`=0:
  - Latch the magnitudes |opa| and |opb|. Use raw values when `signed_div`=0.
  - Latch the quotient sign (opa[31]^opb[31]) and the remainder sign (opa[31]). Both apply in signed mode only.
  - Clear the counter and go to RUN.
- RUN: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial subtract the divisor from the 33-bit partial remainder.
  - If the result is non-negative, keep the difference and set quo[0]=1.
  - After 32 steps go to FINISH.
- FINISH:
  - Apply sign correction (negate the quotient and/or remainder).
  - Write `lo`←quotient and `hi`←remainder, pulse `done`, return to IDLE.
- Division by zero is not trapped and needs no special path; the restoring steps produce the result naturally:
  - Unsigned: `lo`=0xFFFFFFFF, `hi`=opa.
  - Signed: the sign fix-up is applied to those magnitudes.
- Signed 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0. No exception.
- `annul` in RUN or FINISH:
  - Return to IDLE next edge with no `done`.
  - `hi`/`lo` keep their previous values.
- `annul` with `start` in the same IDLE cycle: annul wins and the request is not accepted.
- `start` while not in IDLE is ignored. Operands are not re-sampled.
- `hi`/`lo` hold their values until the next FINISH. They are never cleared except by reset.

## Timing
- Reset values (async, `resetn`=0): state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0, internal shift registers 0.
- Reset asserted mid-operation aborts immediately. No result is written.
- Request accepted at edge T:
  - `busy`=1 over cycles T+1 … T+33 (32 RUN cycles plus 1 FINISH cycle).
  - `done`=1 in cycle T+33 only.
  - The new `hi`/`lo` are visible from T+34.
  - `busy`=0 from T+34.
- `busy` is a registered decode of the state (state ≠ IDLE). No combinational path from `start` to `busy`.
- Back-to-back: a new `start` is accepted in cycle T+34 at the earliest. Minimum issue interval is 34 cycles.
- `annul` sampled at edge A (A within T+1 … T+33): `busy`=0 from A+1.

## Test plan
- Unsigned basic: DIVU opa=100, opb=7, start at T:
  - `busy` high T+1 … T+33, `done` pulse at T+33.
  - `lo`=14, `hi`=2 from T+34.
- Signed mixed sign: DIV opa=0xFFFFFFF9 (−7), opb=2 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1). Also opa=7, opb=0xFFFFFFFE → `lo`=0xFFFFFFFD, `hi`=1.
- Corner operands:
  - DIVU opa=0x12345678, opb=0 → `lo`=0xFFFFFFFF, `hi`=0x12345678.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Annul: start 100/7 after a prior result of `hi`=5, `lo`=9; assert `annul` at T+10.
  - `busy`=0 from T+11, no `done`.
  - `hi`=5, `lo`=9 retained.
- Ignored start: while busy, pulse `start` with opa=50, opb=5 at T+5 → the first result (100/7) still completes at T+33, and no second operation begins.
- Async reset: drop `resetn` at T+20 between clock edges.
  - `busy`, `done`, `hi`, `lo` go to 0 without waiting for a clock edge.
  - After release, a new DIVU 9/3 gives `lo`=3, `hi`=0.
